// File: rtl/shift_reg_pkg.sv
// Shared types for the shift-register sequencer: host opcodes, FSM states and
// the datapath modes the FSM drives into the register core.
package shift_reg_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_SHL  = 2'd1,
      OP_SHR  = 2'd2,
      OP_ROTL = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'd0,
      MODE_LOAD = 3'd1,
      MODE_SHL  = 3'd2,
      MODE_SHR  = 3'd3,
      MODE_ROTL = 3'd4
   } mode_e;

   function automatic mode_e op_to_mode(input op_e op);
      mode_e m;
      unique case (op)
         OP_LOAD: m = MODE_LOAD;
         OP_SHL:  m = MODE_SHL;
         OP_SHR:  m = MODE_SHR;
         OP_ROTL: m = MODE_ROTL;
         default: m = MODE_HOLD;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/shift_register_core.sv
// WIDTH-bit universal shift register; serial_out keeps the last bit shifted
// out and only changes on a shift.
module shift_register_core
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  mode_e            mode,
   input  logic [WIDTH-1:0] d,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             serial_out
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             so_q, so_d;

   always_comb begin
      q_d  = q_q;
      so_d = so_q;
      unique case (mode)
         MODE_LOAD: q_d = d;
         MODE_SHL: begin
            q_d  = {q_q[WIDTH-2:0], serial_in};
            so_d = q_q[WIDTH-1];
         end
         MODE_SHR: begin
            q_d  = {serial_in, q_q[WIDTH-1:1]};
            so_d = q_q[0];
         end
         MODE_ROTL: begin
            q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            so_d = q_q[WIDTH-1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q  <= '0;
         so_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         so_q <= so_d;
      end
   end

   assign q          = q_q;
   assign serial_out = so_q;

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer for the universal shift register: accepts one command,
// steps the core one position per clock, then pulses done.
//
//   state   | meaning
//   S_IDLE  | ready for a command; LOAD applied on the accept edge
//   S_SHIFT | one shift per clock until the remaining count runs out
//   S_DONE  | one-cycle done pulse, commands refused
module shift_reg_sequencer
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   mode_e            core_mode;
   op_e              cmd_op_e;

   assign cmd_op_e = op_e'(cmd_op);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rem_d     = rem_q;
      core_mode = MODE_HOLD;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d = cmd_op_e;
               if (cmd_op_e == OP_LOAD) begin
                  core_mode = MODE_LOAD;
                  state_d   = S_DONE;
               end else if (cmd_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  // over-long counts saturate at one full register width
                  rem_d   = (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            core_mode = op_to_mode(op_q);
            rem_d     = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= OP_LOAD;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
      end
   end

   shift_register_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (core_mode),
      .d          (cmd_data),
      .serial_in  (serial_in),
      .q          (q),
      .serial_out (serial_out)
   );

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

endmodule
